// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the execute-stage multiply scheduler: the funct codes
// that select a multiply and the scheduler state encoding.
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h0e;  // signed multiply
  localparam logic [5:0] FUNCT_MULTU = 6'h16;  // unsigned multiply

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mult_sched.sv
// -----------------------------------------------------------------------------
// mult_sched
// Multi-cycle multiply scheduler for the execute stage. Latches the operands of
// an accepted multiply for the external booth_mult, counts its latency, stalls
// the pipeline while the product is in flight and presents the low product word
// with its destination tag until EX/MEM takes it.
//
// Ports:
//   clk, rst_n            pipeline clock, asynchronous active-low reset
//   issue_valid, alu_ctrl ID/EX instruction valid and its funct code
//   op_a, op_b            forwarded operands
//   dest_reg, fp_dest     destination register and register-file select
//   flush                 squash an in-flight op
//   hold                  EX/MEM cannot take a result this cycle
//   mult_p                product returned by booth_mult
//   mult_a, mult_b        registered operands to booth_mult
//   mult_sign             registered signedness (1 = signed)
//   stall                 pipeline lock to IF/ID/EX
//   result_valid          result/result_reg/result_fp are valid
//   result, result_reg    low product word and its destination register
//   result_fp             destination is in the FP register file
// -----------------------------------------------------------------------------
module mult_sched
  import mult_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [5:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  dest_reg,
  input  logic        fp_dest,
  input  logic        flush,
  input  logic        hold,
  input  logic [63:0] mult_p,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_sign,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_reg,
  output logic        result_fp
);

  localparam int               CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  mult_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       tag_reg_r;
  logic             tag_fp_r;

  logic             is_mul_s;
  logic             accept_s;
  logic             op_zero_s;
  logic             mult_p_hi_unused_s;

  // Only the low product word is returned; the high word is left to other users.
  assign mult_p_hi_unused_s = ^mult_p[63:32];

  // Accept decode and combinational pipeline stall.
  always_comb begin
    is_mul_s  = (alu_ctrl == FUNCT_MULT) || (alu_ctrl == FUNCT_MULTU);
    op_zero_s = (op_a == 32'd0) || (op_b == 32'd0);
    if (issue_valid && is_mul_s && !flush &&
        ((state_r == IDLE) || ((state_r == DONE) && !hold))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    // The accept term must stall ID/EX in the very cycle it is taken.
    stall = accept_s || (state_r == RUN) || (state_r == ZERO) ||
            ((state_r == DONE) && hold);
  end

  // Scheduler FSM with operand, tag and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      tag_reg_r    <= 5'd0;
      tag_fp_r     <= 1'b0;
      mult_a       <= 32'd0;
      mult_b       <= 32'd0;
      mult_sign    <= 1'b0;
      result_valid <= 1'b0;
      result       <= 32'd0;
      result_reg   <= 5'd0;
      result_fp    <= 1'b0;
    end else if (accept_s) begin
      // Accept is only possible from IDLE or a released DONE.
      mult_a       <= op_a;
      mult_b       <= op_b;
      mult_sign    <= (alu_ctrl == FUNCT_MULT);
      tag_reg_r    <= dest_reg;
      tag_fp_r     <= fp_dest;
      cnt_r        <= CNT_LOAD;
      result_valid <= 1'b0;
      state_r      <= op_zero_s ? ZERO : RUN;
    end else begin
      case (state_r)
        IDLE: begin
          state_r      <= IDLE;
          result_valid <= 1'b0;
        end
        RUN: begin
          if (flush) begin
            state_r <= IDLE;
          end else if (cnt_r == CNT_ZERO) begin
            result       <= mult_p[31:0];
            result_reg   <= tag_reg_r;
            result_fp    <= tag_fp_r;
            result_valid <= 1'b1;
            state_r      <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ZERO: begin
          // A zero operand needs no multiplier wait.
          if (flush) begin
            state_r <= IDLE;
          end else begin
            result       <= 32'd0;
            result_reg   <= tag_reg_r;
            result_fp    <= tag_fp_r;
            result_valid <= 1'b1;
            cnt_r        <= CNT_ZERO;
            state_r      <= DONE;
          end
        end
        DONE: begin
          // Result is committed: flush is ignored, hold freezes everything.
          if (!hold) begin
            result_valid <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          result_valid <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// -----------------------------------------------------------------------------
// tb_mult_sched
// Self-checking bench for mult_sched (LATENCY = 4). A delayed multiplier
// stand-in drives mult_p; expectations come from a cycle-count model that
// tracks when each accepted op completes and what its low product word is.
// -----------------------------------------------------------------------------
module tb_mult_sched;

  localparam int L = 4;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [5:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  dest_reg;
  logic        fp_dest;
  logic        flush;
  logic        hold;
  logic [63:0] mult_p;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_sign;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  result_reg;
  logic        result_fp;

  int checks;
  int errors;

  mult_sched #(.LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .dest_reg(dest_reg), .fp_dest(fp_dest),
    .flush(flush), .hold(hold), .mult_p(mult_p), .mult_a(mult_a),
    .mult_b(mult_b), .mult_sign(mult_sign), .stall(stall),
    .result_valid(result_valid), .result(result), .result_reg(result_reg),
    .result_fp(result_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] full_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end else begin
      return {32'd0, a} * {32'd0, b};
    end
  endfunction

  // booth_mult stand-in: product is valid L cycles after operands appear.
  logic [63:0] prod_now;
  logic [63:0] pipe [0:L-2];
  assign prod_now = full_prod(mult_a, mult_b, mult_sign);
  always @(posedge clk) begin
    pipe[0] <= prod_now;
    for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign mult_p = pipe[L-2];

  // Reference model: an op in flight and a result on display, by cycle number.
  int          cyc;
  bit          m_pend;
  int          m_done_cyc;
  logic [31:0] m_pend_res;
  logic [4:0]  m_pend_reg;
  logic        m_pend_fp;
  bit          m_show;
  logic [31:0] m_res;
  logic [4:0]  m_reg;
  logic        m_fp;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_sign;
  bit          exp_accept;
  bit          exp_stall;

  task automatic model_reset();
    cyc = 0; m_pend = 0; m_done_cyc = 0; m_pend_res = 32'd0; m_pend_reg = 5'd0;
    m_pend_fp = 1'b0; m_show = 0; m_res = 32'd0; m_reg = 5'd0; m_fp = 1'b0;
    m_a = 32'd0; m_b = 32'd0; m_sign = 1'b0;
  endtask

  // Drive one cycle's inputs and compute this cycle's expectations at negedge.
  task automatic apply(input logic iv, input logic [5:0] ac, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] dr, input logic fp,
                       input logic fl, input logic hd);
    issue_valid = iv; alu_ctrl = ac; op_a = a; op_b = b;
    dest_reg = dr; fp_dest = fp; flush = fl; hold = hd;
    @(negedge clk);
    exp_accept = iv && (ac == 6'h0e || ac == 6'h16) && !fl && !m_pend && (!m_show || !hd);
    exp_stall  = exp_accept || m_pend || (m_show && hd);
  endtask

  // Close the cycle in the model, then move to just after the next rising edge.
  task automatic advance();
    bit show_n;
    int lat;
    show_n = m_show && hold;
    if (m_pend) begin
      if (flush) begin
        m_pend = 0;
      end else if (cyc + 1 == m_done_cyc) begin
        show_n = 1; m_res = m_pend_res; m_reg = m_pend_reg; m_fp = m_pend_fp; m_pend = 0;
      end
    end
    if (exp_accept) begin
      lat        = (op_a == 32'd0 || op_b == 32'd0) ? 1 : L;
      m_pend     = 1;
      m_done_cyc = cyc + lat + 1;
      m_sign     = (alu_ctrl == 6'h0e);
      m_pend_res = full_prod(op_a, op_b, m_sign) & 64'h0000_0000_FFFF_FFFF;
      m_pend_reg = dest_reg;
      m_pend_fp  = fp_dest;
      m_a        = op_a;
      m_b        = op_b;
    end
    m_show = show_n;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    apply(1'b0, 6'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue_valid = 1'b0; alu_ctrl = 6'h00; op_a = 32'd0; op_b = 32'd0;
    dest_reg = 5'd0; fp_dest = 1'b0; flush = 1'b0; hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mult_a !== 32'd0) begin errors++; $display("FAIL reset_mult_a got %h want 0", mult_a); end
    checks++; if (mult_b !== 32'd0) begin errors++; $display("FAIL reset_mult_b got %h want 0", mult_b); end
    checks++; if (mult_sign !== 1'b0) begin errors++; $display("FAIL reset_mult_sign got %b want 0", mult_sign); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", result_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (result_reg !== 5'd0) begin errors++; $display("FAIL reset_result_reg got %0d want 0", result_reg); end
    checks++; if (result_fp !== 1'b0) begin errors++; $display("FAIL reset_result_fp got %b want 0", result_fp); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_signed();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) apply(1'b1, 6'h0e, 32'd7, 32'hFFFF_FFFD, 5'd13, 1'b0, 1'b0, 1'b0);
      else idle_cycle();
      checks++; if (stall !== (k <= 4)) begin errors++; $display("FAIL signed_stall k=%0d got %b want %b", k, stall, (k <= 4)); end
      checks++; if (result_valid !== (k == 5)) begin errors++; $display("FAIL signed_valid k=%0d got %b want %b", k, result_valid, (k == 5)); end
      if (k == 1) begin
        checks++; if (mult_sign !== 1'b1) begin errors++; $display("FAIL signed_mult_sign got %b want 1", mult_sign); end
      end
      if (k == 5) begin
        checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL signed_result got %h want ffffffeb", result); end
        checks++; if (result_reg !== 5'd13) begin errors++; $display("FAIL signed_result_reg got %0d want 13", result_reg); end
      end
      advance();
    end
  endtask

  task automatic test_unsigned();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) apply(1'b1, 6'h16, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b1, 1'b0, 1'b0);
      else idle_cycle();
      if (k == 1) begin
        checks++; if (mult_sign !== 1'b0) begin errors++; $display("FAIL unsigned_mult_sign got %b want 0", mult_sign); end
      end
      checks++; if (result_valid !== (k == 5)) begin errors++; $display("FAIL unsigned_valid k=%0d got %b want %b", k, result_valid, (k == 5)); end
      if (k == 5) begin
        checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL unsigned_result got %h want fffffffe", result); end
        checks++; if (result_fp !== 1'b1) begin errors++; $display("FAIL unsigned_result_fp got %b want 1", result_fp); end
      end
      advance();
    end
  endtask

  task automatic test_zero();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) apply(1'b1, 6'h0e, 32'd0, 32'h1234, 5'd2, 1'b0, 1'b0, 1'b0);
      else idle_cycle();
      checks++; if (stall !== (k <= 1)) begin errors++; $display("FAIL zero_stall k=%0d got %b want %b", k, stall, (k <= 1)); end
      checks++; if (result_valid !== (k == 2)) begin errors++; $display("FAIL zero_valid k=%0d got %b want %b", k, result_valid, (k == 2)); end
      if (k == 2) begin
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL zero_result got %h want 0", result); end
        checks++; if (result_reg !== 5'd2) begin errors++; $display("FAIL zero_result_reg got %0d want 2", result_reg); end
      end
      advance();
    end
  endtask

  task automatic test_hold_back_to_back();
    for (int k = 0; k < 15; k++) begin
      if (k == 0)                apply(1'b1, 6'h16, 32'd123, 32'd456, 5'd9, 1'b1, 1'b0, 1'b0);
      else if (k == 6)           apply(1'b1, 6'h0e, 32'hAAAA, 32'd3, 5'd1, 1'b0, 1'b0, 1'b1);
      else if (k == 5 || k == 7) apply(1'b0, 6'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      else if (k == 8)           apply(1'b1, 6'h0e, 32'hFFFF_FFFB, 32'd11, 5'd17, 1'b0, 1'b0, 1'b0);
      else idle_cycle();
      if (k >= 5 && k <= 8) begin
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL hold_valid k=%0d got %b want 1", k, result_valid); end
        checks++; if (result !== 32'd56088) begin errors++; $display("FAIL hold_result k=%0d got %0d want 56088", k, result); end
        checks++; if (result_reg !== 5'd9 || result_fp !== 1'b1) begin errors++; $display("FAIL hold_tag k=%0d got %0d/%b want 9/1", k, result_reg, result_fp); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall k=%0d got %b want 1", k, stall); end
      end
      if (k == 7 || k == 8) begin
        checks++; if (mult_a !== 32'd123) begin errors++; $display("FAIL hold_mult_a k=%0d got %h want 7b", k, mult_a); end
      end
      if (k == 9) begin
        checks++; if (mult_a !== 32'hFFFF_FFFB || mult_sign !== 1'b1) begin errors++; $display("FAIL b2b_operands got %h/%b want fffffffb/1", mult_a, mult_sign); end
      end
      if (k >= 9) begin
        checks++; if (result_valid !== (k == 13)) begin errors++; $display("FAIL b2b_valid k=%0d got %b want %b", k, result_valid, (k == 13)); end
      end
      if (k == 13) begin
        checks++; if (result !== 32'hFFFF_FFC9 || result_reg !== 5'd17) begin errors++; $display("FAIL b2b_result got %h/%0d want ffffffc9/17", result, result_reg); end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 9; k++) begin
      if (k == 0)      apply(1'b1, 6'h0e, 32'd3, 32'd5, 5'd4, 1'b0, 1'b0, 1'b0);
      else if (k == 2) apply(1'b0, 6'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      else if (k == 3) apply(1'b1, 6'h0e, 32'd9, 32'd9, 5'd8, 1'b0, 1'b1, 1'b0);
      else if (k == 4) apply(1'b1, 6'h20, 32'd9, 32'd9, 5'd8, 1'b0, 1'b0, 1'b0);
      else idle_cycle();
      if (k >= 3) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall k=%0d got %b want 0", k, stall); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL flush_valid k=%0d got %b want 0", k, result_valid); end
      end
      if (k == 5) begin
        checks++; if (mult_a !== 32'd3) begin errors++; $display("FAIL flush_mult_a got %h want 3", mult_a); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) apply(1'b1, 6'h0e, 32'h1000, 32'h10, 5'd3, 1'b1, 1'b0, 1'b0);
      else idle_cycle();
      if (k < 3) advance();
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({mult_a, mult_b, mult_sign, stall, result_valid, result, result_reg, result_fp} !== 105'd0) begin
      errors++; $display("FAIL midrst_outputs got a=%h b=%h s=%b st=%b v=%b r=%h rr=%0d fp=%b want all 0",
                         mult_a, mult_b, mult_sign, stall, result_valid, result, result_reg, result_fp);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) apply(1'b1, 6'h16, 32'h0001_0001, 32'd3, 5'd21, 1'b0, 1'b0, 1'b0);
      else idle_cycle();
      checks++; if (stall !== (k <= 4)) begin errors++; $display("FAIL midrst_stall k=%0d got %b want %b", k, stall, (k <= 4)); end
      checks++; if (result_valid !== (k == 5)) begin errors++; $display("FAIL midrst_valid k=%0d got %b want %b", k, result_valid, (k == 5)); end
      if (k == 5) begin
        checks++; if (result !== 32'h0003_0003 || result_reg !== 5'd21) begin errors++; $display("FAIL midrst_result got %h/%0d want 00030003/21", result, result_reg); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic        iv;
    logic [5:0]  ac;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    for (int n = 0; n < 400; n++) begin
      iv  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      ac  = (sel <= 1) ? 6'h0e : (sel == 2) ? 6'h16 : 6'h20;
      a   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      apply(iv, ac, a, b, 5'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) == 0));
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rand_stall n=%0d got %b want %b", n, stall, exp_stall); end
      checks++; if (result_valid !== m_show) begin errors++; $display("FAIL rand_valid n=%0d got %b want %b", n, result_valid, m_show); end
      checks++; if (result !== m_res || result_reg !== m_reg || result_fp !== m_fp) begin
        errors++; $display("FAIL rand_result n=%0d got %h/%0d/%b want %h/%0d/%b", n, result, result_reg, result_fp, m_res, m_reg, m_fp);
      end
      checks++; if (mult_a !== m_a || mult_b !== m_b || mult_sign !== m_sign) begin
        errors++; $display("FAIL rand_operands n=%0d got %h/%h/%b want %h/%h/%b", n, mult_a, mult_b, mult_sign, m_a, m_b, m_sign);
      end
      advance();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_signed();
    test_unsigned();
    test_zero();
    test_hold_back_to_back();
    test_flush();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
